stack_unit: RTL

Parametrised LIFO operand stack for the multicycle stack-machine datapath. It is the generalised successor to the fixed 8-bit push/pop/top stack, with configurable width and depth. It adds a push+pop replace operation, combinational top/next-of-top read ports for binary ALU ops, occupancy count, full/empty status, and sticky overflow/underflow error flags. The controller drives push/pop/top exactly as today; ALU operands come from tos_out/nos_out.

---
 rtl/stack_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// Parametrised LIFO operand stack: push/pop/top/replace with combinational
// top/next-of-top read ports, occupancy count and sticky error flags.
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] tos_out,
  output logic [WIDTH-1:0] nos_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [AW-1:0]    top_idx, nos_idx, push_idx, mem_idx;
  logic             mem_we;

  // Indices are only used when the corresponding entry is valid, so the
  // truncation never discards a meaningful bit.
  assign top_idx  = AW'(sp_q - CNT_W'(1));
  assign nos_idx  = AW'(sp_q - CNT_W'(2));
  assign push_idx = AW'(sp_q);

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == DepthC);
  assign count     = sp_q;
  assign d_out     = d_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign tos_out   = empty ? '0 : mem_q[top_idx];
  assign nos_out   = (sp_q < CNT_W'(2)) ? '0 : mem_q[nos_idx];

  always_comb begin
    sp_d        = sp_q;
    d_out_d     = d_out_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    mem_we      = 1'b0;
    mem_idx     = push_idx;

    if (push && pop) begin
      // Replace: read old top and overwrite it in the same edge.
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        d_out_d = mem_q[top_idx];
        mem_we  = 1'b1;
        mem_idx = top_idx;
      end
    end else if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        mem_idx = push_idx;
        sp_d    = sp_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        d_out_d = mem_q[top_idx];
        sp_d    = sp_q - CNT_W'(1);
      end
    end else if (top) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        d_out_d = mem_q[top_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q        <= '0;
      d_out_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      d_out_q     <= d_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_idx] <= d_in;
    end
  end

endmodule
